// File: rtl/window3x3_gen.sv
// window3x3_gen: raster pixel stream to 3x3 neighbourhoods via two line buffers and a shift window
module window3x3_gen #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] pix_i,
  input  logic              pix_valid_i,
  input  logic              sof_i,
  output logic              pix_ready_o,
  output logic [DATA_W-1:0] data_o_0,
  output logic [DATA_W-1:0] data_o_1,
  output logic [DATA_W-1:0] data_o_2,
  output logic [DATA_W-1:0] data_o_3,
  output logic [DATA_W-1:0] data_o_4,
  output logic [DATA_W-1:0] data_o_5,
  output logic [DATA_W-1:0] data_o_6,
  output logic [DATA_W-1:0] data_o_7,
  output logic [DATA_W-1:0] data_o_8,
  output logic              win_valid_o,
  output logic              win_last_o,
  input  logic              win_ready_i
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  logic [CW-1:0]     col, col_e;
  logic [RW-1:0]     row, row_e;
  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] win [9];
  logic [DATA_W-1:0] win_n [9];
  logic [DATA_W-1:0] dout [9];
  logic              acc, emit, last_n;
  assign pix_ready_o = ~win_valid_o | win_ready_i;
  assign acc = pix_valid_i & pix_ready_o;
  // Effective position (sof forces (0,0)), emit decision and post-shift window
  always_comb begin
    col_e  = sof_i ? '0 : col;
    row_e  = sof_i ? '0 : row;
    emit   = acc && row_e >= RW'(2) && col_e >= CW'(2);
    last_n = row_e == ROW_MAX && col_e == COL_MAX;
    for (int r = 0; r < 3; r++) begin
      win_n[3*r]   = win[3*r+1];
      win_n[3*r+1] = win[3*r+2];
    end
    win_n[2] = lb1[col_e];
    win_n[5] = lb0[col_e];
    win_n[8] = pix_i;
  end
  // Raster position counters; sof restarts the frame at the accepted pixel
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col <= '0;
      row <= '0;
    end else if (acc) begin
      col <= col_e == COL_MAX ? '0 : col_e + CW'(1);
      row <= col_e != COL_MAX ? row_e : row_e == ROW_MAX ? '0 : row_e + RW'(1);
    end
  end
  // Line buffers: lb0 keeps the previous row, lb1 the one before it; contents need no reset
  always_ff @(posedge clk_i) begin
    if (acc) begin
      lb1[col_e] <= lb0[col_e];
      lb0[col_e] <= pix_i;
    end
  end
  // 3x3 shift window advances one column per accepted pixel
  always_ff @(posedge clk_i) begin
    if (rst_i) win <= '{default: '0};
    else if (acc) win <= win_n;
  end
  // Output register: load on emit, hold while stalled, drop valid once handed off
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dout        <= '{default: '0};
      win_valid_o <= 1'b0;
      win_last_o  <= 1'b0;
    end else if (emit) begin
      dout        <= win_n;
      win_valid_o <= 1'b1;
      win_last_o  <= last_n;
    end else if (win_ready_i) begin
      win_valid_o <= 1'b0;
      win_last_o  <= 1'b0;
    end
  end
  assign data_o_0 = dout[0];
  assign data_o_1 = dout[1];
  assign data_o_2 = dout[2];
  assign data_o_3 = dout[3];
  assign data_o_4 = dout[4];
  assign data_o_5 = dout[5];
  assign data_o_6 = dout[6];
  assign data_o_7 = dout[7];
  assign data_o_8 = dout[8];
endmodule

// File: doc/window3x3_gen.md
Name: window3x3_gen

Overview:
Upstream stage of the laplacian filter. Converts a raster pixel stream into 3x3 neighbourhoods using two line buffers and a 3x3 shift window. Emits one window per interior pixel on data_o_0..data_o_8, which connect directly to the filter's data_i_0..data_i_8. Uses valid/ready flow control on both sides.

Parameters:
IMG_W, 640, pixels per line (>=3)
IMG_H, 480, lines per frame (>=3)
DATA_W, 8, pixel width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset; synchronous, active-high
pix_i  in  DATA_W  input pixel, raster order
pix_valid_i  in  1  pix_i valid
sof_i  in  1  qualifies the current pixel as frame pixel (0,0)
pix_ready_o  out  1  block accepts pixel this cycle
data_o_0 .. data_o_8  out  DATA_W each  window, row-major; 0 = top-left, 4 = centre, 8 = bottom-right
win_valid_o  out  1  window valid
win_last_o  out  1  last window of frame; valid only with win_valid_o
win_ready_i  in  1  downstream accepts window

Behaviour:
- Accept: acc = pix_valid_i & pix_ready_o. pix_ready_o = ~win_valid_o | win_ready_i, combinational.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) give the position of the pixel being accepted.
- Counter update on acc:
  - col wraps to 0 after IMG_W-1, and row then increments.
  - row wraps to 0 after IMG_H-1 at col IMG_W-1.
- sof_i on acc: the pixel is treated as (0,0), and next position is (0,1), regardless of the current count. This applies even mid-frame. sof_i without acc is ignored.
- Line buffers: lb1 holds row-2 and lb0 holds row-1. Each is IMG_W x DATA_W. On acc at col c:
  - lb1[c] <= lb0[c]
  - lb0[c] <= pix_i
  - The incoming window column is {lb1[c], lb0[c], pix_i} (top, mid, bottom).
- Window register: on acc, the 3x3 shift window shifts one column left and the incoming column enters on the right.
- Emit condition: row>=2 and col>=2 on acc.
  - Output registers load the post-shift window.
  - win_valid_o is set the next cycle, giving latency 1 from accept of the bottom-right pixel.
  - win_last_o = (row==IMG_H-1 && col==IMG_W-1).
- Valid hold: win_valid_o clears on win_ready_i & ~(new emit). A simultaneous handoff and new emit keeps win_valid_o=1 with the new data.
- Output stability: data_o_*, win_valid_o and win_last_o hold stable while win_valid_o & ~win_ready_i.
- Border pixels (row<2 or col<2) update the buffers and window but produce no output. Each frame yields (IMG_W-2)*(IMG_H-2) windows.
- Reset: col=0, row=0, win_valid_o=0, win_last_o=0, data_o_* = 0, window registers = 0. Line buffer contents are not reset. Stale contents are never emitted because emission requires row>=2 within the current frame.
- Reset mid-frame: the next accepted pixel is (0,0). Any pending window is dropped.
- sof mid-frame: same as reset for counters. The pending output window is still delivered normally.
- Back-to-back frames: no bubble is required. Pixel (0,0) of frame N+1 may be accepted the cycle after the last pixel of frame N.
- Throughput: 1 pixel/cycle while win_ready_i=1.

Test Plan:
- IMG_W=5, IMG_H=4, stream p=row*5+col (0..19), win_ready_i=1, sof_i on p=0:
  - exactly 6 windows;
  - first window, 1 cycle after accepting 12: 0,1,2,5,6,7,10,11,12;
  - last window: 7,8,9,12,13,14,17,18,19 with win_last_o=1, on that window only.
- Same stream, win_ready_i low for 4 cycles while win_valid_o=1:
  - pix_ready_o=0;
  - data_o_* and win_valid_o frozen at the current window;
  - stream resumes with no lost or duplicated window (6 total, order preserved).
- Two back-to-back frames (second frame values +100):
  - 12 windows;
  - frame-2 first window = 100,101,102,105,106,107,110,111,112, with no frame-1 data.
- rst_i asserted after pixel 13:
  - next cycle win_valid_o=0 and data_o_*=0;
  - a fresh 20-pixel frame gives the same 6 windows as scenario 1.
- sof_i asserted with pixel value 50 at former position (2,3):
  - counters restart;
  - no window is emitted until 12 more pixels;
  - windows contain only post-sof data.
- pix_valid_i toggling every other cycle: same 6 windows and values as scenario 1, each one cycle after its bottom-right pixel.
